// File: rtl/sa_tile_feeder.sv
// Upstream sequencer for the NxN systolic MAC array: skews x/w vectors onto the
// array edges, injects the banking clear, then times the shift-out and result flags.
module sa_tile_feeder #(
    parameter int N  = 8,
    parameter int W  = 32,
    parameter int KW = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [KW-1:0]       k_len,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0][W-1:0] x_vec,
    input  logic [N-1:0][W-1:0] w_vec,
    output logic [N-1:0][W-1:0] arr_x,
    output logic [N-1:0][W-1:0] arr_w,
    output logic [N-1:0]        arr_clear,
    output logic [N-1:0]        arr_shift,
    output logic                arr_en,
    output logic [N-1:0]        row_valid,
    output logic                busy,
    output logic                done
);

    localparam int DRAIN_LAST = 3 * N;
    localparam int DW         = $clog2(DRAIN_LAST + 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t              state_r;
    logic [KW-1:0]       k_len_r;
    logic [KW-1:0]       step_r;
    logic [DW-1:0]       drain_cnt_r;
    logic                in_ready_r;
    logic                busy_r;
    logic                done_r;
    logic [N-1:0]        arr_shift_r;
    logic [N-1:0]        row_valid_r;

    logic                accept_s;
    logic                arr_en_s;
    logic [DW-1:0]       drain_nxt_s;
    logic [N-1:0][W-1:0] x_src_s;
    logic [N-1:0][W-1:0] w_src_s;
    logic                clr_src_s;

    // Handshake and global array enable; the array only advances on real slots.
    always_comb begin
        accept_s    = 1'b0;
        arr_en_s    = 1'b0;
        drain_nxt_s = drain_cnt_r + {{(DW-1){1'b0}}, 1'b1};
        if (reset) begin
            accept_s = 1'b0;
            arr_en_s = 1'b0;
        end else begin
            accept_s = (state_r == STREAM) && in_valid && in_ready_r;
            arr_en_s = accept_s || (state_r == FLUSH) || (state_r == DRAIN);
        end
    end

    // Slot entering the skew pipeline: data while streaming, the banking clear in FLUSH, zeros otherwise.
    always_comb begin
        x_src_s   = '0;
        w_src_s   = '0;
        clr_src_s = 1'b0;
        case (state_r)
            STREAM: begin
                x_src_s   = x_vec;
                w_src_s   = w_vec;
                clr_src_s = (step_r == {KW{1'b0}});
            end
            FLUSH: begin
                clr_src_s = 1'b1;
            end
            default: begin
                clr_src_s = 1'b0;
            end
        endcase
    end

    // Tile sequencer with registered handshake, status and drain-timing outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            k_len_r     <= {KW{1'b0}};
            step_r      <= {KW{1'b0}};
            drain_cnt_r <= {DW{1'b0}};
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            arr_shift_r <= {N{1'b0}};
            row_valid_r <= {N{1'b0}};
        end else begin
            done_r      <= 1'b0;
            arr_shift_r <= {N{1'b0}};
            row_valid_r <= {N{1'b0}};
            case (state_r)
                IDLE: begin
                    if (start) begin
                        k_len_r <= k_len;
                        step_r  <= {KW{1'b0}};
                        busy_r  <= 1'b1;
                        if (k_len == {KW{1'b0}}) begin
                            state_r    <= FLUSH;
                            in_ready_r <= 1'b0;
                        end else begin
                            state_r    <= STREAM;
                            in_ready_r <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (accept_s) begin
                        step_r <= step_r + {{(KW-1){1'b0}}, 1'b1};
                        if ((step_r + {{(KW-1){1'b0}}, 1'b1}) == k_len_r) begin
                            state_r    <= FLUSH;
                            in_ready_r <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    state_r     <= DRAIN;
                    drain_cnt_r <= {DW{1'b0}};
                end
                DRAIN: begin
                    // drain_cnt_r counts cycles since row 0 saw the banking clear.
                    drain_cnt_r <= drain_nxt_s;
                    for (int i = 0; i < N; i++) begin
                        arr_shift_r[i] <= (drain_nxt_s == DW'(N + i));
                        row_valid_r[i] <= (drain_nxt_s >= DW'(N + 1 + i)) &&
                                          (drain_nxt_s <= DW'(2 * N + i));
                    end
                    done_r <= (drain_nxt_s == DW'(DRAIN_LAST));
                    if (drain_cnt_r == DW'(DRAIN_LAST)) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // Lane i carries an (i+1)-deep delay line, advancing only on enabled cycles.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [W-1:0] x_sr  [0:i];
        logic [W-1:0] w_sr  [0:i];
        logic         cl_sr [0:i];

        // Diagonal skew registers for row i of x/clear and column i of w.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int s = 0; s <= i; s++) begin
                    x_sr[s]  <= {W{1'b0}};
                    w_sr[s]  <= {W{1'b0}};
                    cl_sr[s] <= 1'b0;
                end
            end else if (arr_en_s) begin
                x_sr[0]  <= x_src_s[i];
                w_sr[0]  <= w_src_s[i];
                cl_sr[0] <= clr_src_s;
                for (int s = 1; s <= i; s++) begin
                    x_sr[s]  <= x_sr[s-1];
                    w_sr[s]  <= w_sr[s-1];
                    cl_sr[s] <= cl_sr[s-1];
                end
            end
        end

        assign arr_x[i]     = x_sr[i];
        assign arr_w[i]     = w_sr[i];
        assign arr_clear[i] = cl_sr[i];
    end

    assign in_ready  = in_ready_r;
    assign arr_en    = arr_en_s;
    assign arr_shift = arr_shift_r;
    assign row_valid = row_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: doc/sa_tile_feeder.md
Name: sa_tile_feeder

Overview:
- Upstream sequencer for the 8x8 systolic MAC array.
- Accepts one unskewed x column vector and one w row vector per handshake, for K handshakes per tile.
- Skews them diagonally onto the array's x_in/w_in edges and generates per-row clear_in and shift.
- Drives the global array enable, which stalls the array when input is starved, and flags when each row's results appear on z_out.

Parameters:
N, 8, array dimension (rows = columns); fixed to match the array
W, 32, data width of every lane
KW, 16, width of the tile-length field

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset; also drives the array's reset
start  in  1  begin a tile; sampled only in IDLE
k_len  in  KW  number of vector pairs in the tile; latched on start
in_valid  in  1  x_vec/w_vec valid
in_ready  out  1  feeder accepts a vector pair this cycle
x_vec  in  W x N  x values for rows 0..N-1, step k
w_vec  in  W x N  w values for columns 0..N-1, step k
arr_x  out  W x N  to array x_in[i]
arr_w  out  W x N  to array w_in[j]
arr_clear  out  N  to array clear_in[i]
arr_shift  out  N  to array shift[i]
arr_en  out  1  to array enable
row_valid  out  N  array z_out[i] carries a result this cycle
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at tile end

Behaviour:
- Reset (synchronous, active-high) has priority over everything:
  - Every output goes to 0; state goes to IDLE; all skew and counter registers clear.
  - The same rule applies mid-tile: the partial tile is abandoned.
- State machine: IDLE -> STREAM -> FLUSH -> DRAIN -> IDLE.
- IDLE:
  - start=1 latches k_len and zeroes the step counter.
  - Goes to STREAM, or to FLUSH if k_len==0.
  - start is ignored in every other state.
- STREAM:
  - in_ready=1.
  - A pair is accepted when in_valid && in_ready. arr_en=1 on accept cycles and 0 otherwise.
  - With arr_en=0, the feeder's skew pipeline and the array both freeze; no bubbles are inserted.
  - The pair accepted as step 0 carries clear=1; later steps carry clear=0.
  - After the k_len-th accept, go to FLUSH.
- Skew (all delays counted in arr_en=1 cycles; registered outputs):
  - x_vec[i] and its clear bit appear on arr_x[i]/arr_clear[i] i+1 enabled cycles after accept.
  - w_vec[j] appears on arr_w[j] j+1 enabled cycles after accept.
  - Unfilled skew slots present 0 data, clear 0.
- FLUSH:
  - One unskewed slot with x=0, w=0, clear=1. It banks every accumulator into standby and zeroes acc.
  - Let F = cycle in which that slot's row-0 clear is on arr_clear[0].
  - Row i clear is on arr_clear[i] at F+i.
  - From FLUSH onward arr_en=1 continuously and in_ready=0.
- DRAIN:
  - Injects zeros.
  - arr_shift[i] is a single-cycle pulse at F+i+8, after the row-i clear has passed column N-1.
  - row_valid[i]=1 for cycles F+i+9 .. F+i+16. During these cycles z_out[i] presents columns 0..7 in order.
  - done=1 at F+24; state returns to IDLE the same cycle. busy=0 from the next cycle.
- The tile result is Y[i][j] = sum over k of x_k[i]*w_k[j], using the array's arithmetic. The feeder performs no arithmetic.
- Back-to-back tiles: start asserted on the cycle after done is accepted.
- The array's conf is not driven by this block.

Test Plan:
1. Reset mid-STREAM (after 2 of 4 accepts):
   - Next cycle: arr_en=0, in_ready=0, arr_x/arr_w/arr_clear/arr_shift all 0, busy=0.
   - A new start then runs cleanly.
2. k_len=1, x_vec all ONE (1.0 in the array format), w_vec all ONE, in_valid held:
   - arr_clear[i] first pulses at accept+i+1.
   - arr_shift[i] at F+i+8.
   - Every z_out[i] column reads ONE under row_valid.
   - done at F+24.
3. k_len=8, X=identity columns, w_vec[k] = row k of a known matrix B:
   - The collected row_valid stream equals B exactly, row i at F+i+9..F+i+16.
4. Stall: k_len=4, in_valid low for 3 cycles after the 2nd accept:
   - arr_en=0 for exactly those 3 cycles, with arr_x held.
   - The result matches the unstalled run; F is shifted by 3.
5. k_len=0:
   - No in_ready pulse.
   - FLUSH immediately; all 64 results read 0; done at F+24.
6. start asserted while busy, with a different k_len:
   - Ignored; the tile completes with the original k_len.
   - start on the cycle after done launches the second tile correctly.
